mux_nbit_x4_rr: RTL and testbench

Four-channel, parameterised-width merge block. It is the collecting end of the 1-to-4 demux path: four independent `BUS_WIDTH` streams (`a`, `b`, `c`, `d`) are arbitrated round-robin onto a single registered output `y`. The output carries a source tag `sel` so a downstream `demux_nbit_x4` can re-split the stream. Every channel uses a valid/ready handshake, and the output stage is a one-entry register that sustains one transfer per cycle.

---
 rtl/mux_nbit_x4_pkg.sv | 20 ++
 rtl/mux_nbit_x4_rr_arb.sv | 38 +++
 rtl/mux_nbit_x4_rr.sv | 121 ++++++++++++
 tb/tb_mux_nbit_x4_rr.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_nbit_x4_pkg.sv
// Shared constants and types for the four-channel round-robin merge block.
// Counter width applies only when MUX_NBIT_X4_RR_STATS_EN is defined.
package mux_nbit_x4_pkg;

   localparam int CH_W = 2;
   localparam int CNT_W = 16;

   localparam logic [CH_W-1:0] CH_A = 2'd0;
   localparam logic [CH_W-1:0] CH_B = 2'd1;
   localparam logic [CH_W-1:0] CH_C = 2'd2;
   localparam logic [CH_W-1:0] CH_D = 2'd3;

   localparam logic [CH_W-1:0] LAST_RST = CH_D;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/mux_nbit_x4_rr_arb.sv
// Four-way rotating-priority arbiter.
// The search starts one past the most recently granted channel.
module rr_arbiter_x4
   import mux_nbit_x4_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [3:0]      req,
   input  logic            advance,
   output logic [CH_W-1:0] grant,
   output logic            grant_valid
);

   logic [CH_W-1:0] last;
   logic [CH_W-1:0] idx;

   always_ff @(posedge clk) begin
      if (reset)
         last <= LAST_RST;
      else if (advance && grant_valid)
         last <= grant;
   end

   // Order last+1, last+2, last+3, last; wraps through the 2-bit add.
   always_comb begin
      grant = last;
      grant_valid = 1'b0;
      idx = last;
      for (int i = 1; i <= 4; i++) begin
         idx = last + CH_W'(i);
         if (!grant_valid && req[idx]) begin
            grant = idx;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_nbit_x4_rr.sv
// Four-channel round-robin merge onto one registered output with source tag.
// MUX_NBIT_X4_RR_STATS_EN adds saturating per-channel accept counters.
module mux_nbit_x4_rr
   import mux_nbit_x4_pkg::*;
#(
   parameter int BUS_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BUS_WIDTH-1:0] a,
   input  logic [BUS_WIDTH-1:0] b,
   input  logic [BUS_WIDTH-1:0] c,
   input  logic [BUS_WIDTH-1:0] d,
   input  logic                 a_valid,
   input  logic                 b_valid,
   input  logic                 c_valid,
   input  logic                 d_valid,
   output logic                 a_ready,
   output logic                 b_ready,
   output logic                 c_ready,
   output logic                 d_ready,
   output logic [BUS_WIDTH-1:0] y,
   output logic [CH_W-1:0]      sel,
   output logic                 y_valid,
   input  logic                 y_ready
`ifdef MUX_NBIT_X4_RR_STATS_EN
   ,
   output logic [CNT_W-1:0]     cnt_a,
   output logic [CNT_W-1:0]     cnt_b,
   output logic [CNT_W-1:0]     cnt_c,
   output logic [CNT_W-1:0]     cnt_d
`endif
);

   out_state_t state, state_nx;

   logic [3:0]           req;
   logic [CH_W-1:0]      grant;
   logic                 grant_valid;
   logic                 load_en;
   logic                 accept;
   logic [BUS_WIDTH-1:0] win;

   assign req = {d_valid, c_valid, b_valid, a_valid};

   rr_arbiter_x4 u_arb (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .advance     (accept),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   assign load_en = (state == EMPTY) || y_ready;
   // Gating with reset keeps a word from leaking through a reset edge.
   assign accept  = load_en && grant_valid && !reset;

   assign a_ready = accept && (grant == CH_A);
   assign b_ready = accept && (grant == CH_B);
   assign c_ready = accept && (grant == CH_C);
   assign d_ready = accept && (grant == CH_D);

   always_comb begin
      win = a;
      case (grant)
         CH_A:    win = a;
         CH_B:    win = b;
         CH_C:    win = c;
         default: win = d;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= EMPTY;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (accept)
         state_nx = FULL;
      else if (state == FULL && y_ready)
         state_nx = EMPTY;
   end

   assign y_valid = (state == FULL);

   always_ff @(posedge clk) begin
      if (reset) begin
         y   <= '0;
         sel <= CH_A;
      end else if (accept) begin
         y   <= win;
         sel <= grant;
      end
   end

`ifdef MUX_NBIT_X4_RR_STATS_EN
   logic [CNT_W-1:0] cnt [4];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++)
            cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (accept && grant == CH_W'(i) && cnt[i] != '1)
               cnt[i] <= cnt[i] + 1'b1;
      end
   end

   assign cnt_a = cnt[0];
   assign cnt_b = cnt[1];
   assign cnt_c = cnt[2];
   assign cnt_d = cnt[3];
`endif

endmodule

// File: tb/tb_mux_nbit_x4_rr.sv
// Directed bench for mux_nbit_x4_rr with a reference model and scoreboard.
// Counter checks are compiled in when MUX_NBIT_X4_RR_STATS_EN is defined.
module tb_mux_nbit_x4_rr;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] dv [4];
   logic [3:0]   vv;
   logic         yr;

   logic         a_ready, b_ready, c_ready, d_ready;
   logic [W-1:0] y;
   logic [1:0]   sel;
   logic         y_valid;
`ifdef MUX_NBIT_X4_RR_STATS_EN
   logic [15:0]  cnt_a, cnt_b, cnt_c, cnt_d;
`endif

   int checks = 0;
   int failures = 0;

   logic         m_yv;
   logic [W-1:0] m_y;
   logic [1:0]   m_sel;
   logic [1:0]   m_last;
   logic [15:0]  m_cnt [4];
   logic [9:0]   sb [$];

   always #5 clk = ~clk;

   mux_nbit_x4_rr #(.BUS_WIDTH(W)) dut (
      .clk     (clk),
      .reset   (rst),
      .a       (dv[0]),
      .b       (dv[1]),
      .c       (dv[2]),
      .d       (dv[3]),
      .a_valid (vv[0]),
      .b_valid (vv[1]),
      .c_valid (vv[2]),
      .d_valid (vv[3]),
      .a_ready (a_ready),
      .b_ready (b_ready),
      .c_ready (c_ready),
      .d_ready (d_ready),
      .y       (y),
      .sel     (sel),
      .y_valid (y_valid),
      .y_ready (yr)
`ifdef MUX_NBIT_X4_RR_STATS_EN
      ,
      .cnt_a   (cnt_a),
      .cnt_b   (cnt_b),
      .cnt_c   (cnt_c),
      .cnt_d   (cnt_d)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns {found, index} using the rotating search order.
   function automatic logic [2:0] pick(input logic [1:0] last,
                                       input logic [3:0] v);
      logic [1:0] k;
      for (int i = 1; i <= 4; i++) begin
         k = last + 2'(i);
         if (v[k]) return {1'b1, k};
      end
      return 3'b000;
   endfunction

   task automatic model_reset();
      m_yv = 1'b0;
      m_y = '0;
      m_sel = 2'd0;
      m_last = 2'd3;
      for (int i = 0; i < 4; i++) m_cnt[i] = '0;
      sb.delete();
   endtask

   task automatic cyc(input bit quiet = 1'b0);
      logic [2:0] pk;
      logic       acc;
      logic [3:0] er;
      logic [9:0] e;
      #1;
      pk = pick(m_last, vv);
      acc = (!m_yv || yr) && pk[2] && !rst;
      er = acc ? (4'b0001 << pk[1:0]) : 4'b0000;
      if (!quiet || er != {d_ready, c_ready, b_ready, a_ready})
         chk("ready", {28'd0, d_ready, c_ready, b_ready, a_ready},
             {28'd0, er});
      if (acc) sb.push_back({pk[1:0], dv[pk[1:0]]});
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
      end else if (acc) begin
         e = sb.pop_front();
         m_sel = e[9:8];
         m_y = e[7:0];
         m_yv = 1'b1;
         m_last = pk[1:0];
         if (m_cnt[pk[1:0]] != 16'hFFFF)
            m_cnt[pk[1:0]] = m_cnt[pk[1:0]] + 16'd1;
      end else if (m_yv && yr) begin
         m_yv = 1'b0;
      end
      if (!quiet) begin
         chk("y_valid", {31'd0, y_valid}, {31'd0, m_yv});
         chk("y", {24'd0, y}, {24'd0, m_y});
         chk("sel", {30'd0, sel}, {30'd0, m_sel});
`ifdef MUX_NBIT_X4_RR_STATS_EN
         chk("cnt_a", {16'd0, cnt_a}, {16'd0, m_cnt[0]});
         chk("cnt_b", {16'd0, cnt_b}, {16'd0, m_cnt[1]});
         chk("cnt_c", {16'd0, cnt_c}, {16'd0, m_cnt[2]});
         chk("cnt_d", {16'd0, cnt_d}, {16'd0, m_cnt[3]});
`endif
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      vv = 4'b1111;
      yr = 1'b1;
      dv[0] = 8'hA0; dv[1] = 8'hB1; dv[2] = 8'hC2; dv[3] = 8'hD3;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();
      chk("rst_y", {24'd0, y}, 32'h0);
      chk("rst_sel", {30'd0, sel}, 32'h0);
      chk("rst_yv", {31'd0, y_valid}, 32'h0);

      // Single word on b, then drain.
      vv = 4'b0010;
      dv[1] = 8'h5A;
      cyc();
      chk("b_word_y", {24'd0, y}, 32'h5A);
      chk("b_word_sel", {30'd0, sel}, 32'd1);
      vv = 4'b0000;
      cyc();
      chk("b_drain_yv", {31'd0, y_valid}, 32'd0);

      // Fairness from reset: sel must rotate 0,1,2,3,0,1,2,3.
      do_reset();
      vv = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("rotate_sel", {30'd0, sel}, 32'(i % 4));
         chk("rotate_yv", {31'd0, y_valid}, 32'd1);
      end

      // Backpressure for 3 cycles on channel a.
      vv = 4'b0001;
      dv[0] = 8'h11;
      cyc();
      dv[0] = 8'h22;
      yr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall_y", {24'd0, y}, 32'h11);
      end
      yr = 1'b1;
      cyc();
      chk("resume_y", {24'd0, y}, 32'h22);

      // Pointer left at c; with c and d requesting, d wins then c.
      vv = 4'b0100;
      cyc();
      vv = 4'b1100;
      cyc();
      chk("ptr_d", {30'd0, sel}, 32'd3);
      cyc();
      chk("ptr_c", {30'd0, sel}, 32'd2);

      // Reset while full and stalled.
      yr = 1'b0;
      vv = 4'b0010;
      cyc();
      rst = 1'b1;
      vv = 4'b1111;
      cyc();
      rst = 1'b0;
      chk("mid_rst_yv", {31'd0, y_valid}, 32'd0);
      chk("mid_rst_y", {24'd0, y}, 32'd0);
      yr = 1'b1;
      cyc();
      chk("post_rst_sel", {30'd0, sel}, 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 60; i++) begin
         vv = 4'($urandom_range(0, 15));
         yr = 1'($urandom_range(0, 1));
         for (int j = 0; j < 4; j++)
            if (!vv[j]) dv[j] = 8'($urandom);
         cyc();
      end

`ifdef MUX_NBIT_X4_RR_STATS_EN
      yr = 1'b1;
      do_reset();
      vv = 4'b0001;
      for (int i = 0; i < 5; i++) cyc();
      vv = 4'b1000;
      for (int i = 0; i < 2; i++) cyc();
      chk("stat_a", {16'd0, cnt_a}, 32'd5);
      chk("stat_b", {16'd0, cnt_b}, 32'd0);
      chk("stat_c", {16'd0, cnt_c}, 32'd0);
      chk("stat_d", {16'd0, cnt_d}, 32'd2);
      vv = 4'b0001;
      for (int i = 0; i < 65535; i++) cyc(1'b1);
      cyc();
      chk("stat_sat", {16'd0, cnt_a}, 32'hFFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
